// File: rtl/sub_word.sv
// AES key-schedule SubWord: four independent forward S-box lanes behind one
// register stage, with a valid bit that follows in_valid by one clock.

module sub_word_lane (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = SBOX[i_byte];
endmodule

module sub_word (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] S0_in,
    input  logic [7:0] S1_in,
    input  logic [7:0] S2_in,
    input  logic [7:0] S3_in,
    output logic       out_valid,
    output logic [7:0] D0_out,
    output logic [7:0] D1_out,
    output logic [7:0] D2_out,
    output logic [7:0] D3_out
);
    localparam int NUM_LANES = 4;

    // Lane 3 is the most significant byte (S0/D0), so the packed word reads in wire order.
    logic [NUM_LANES-1:0][7:0] w_in;
    logic [NUM_LANES-1:0][7:0] w_sub;
    logic [NUM_LANES-1:0][7:0] r_d;
    logic                      r_vld;

    assign w_in = {S0_in, S1_in, S2_in, S3_in};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        sub_word_lane u_lane (
            .i_byte (w_in[g]),
            .o_byte (w_sub[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) r_d <= w_sub;
        end
    end

    assign out_valid = r_vld;
    assign D0_out    = r_d[3];
    assign D1_out    = r_d[2];
    assign D2_out    = r_d[1];
    assign D3_out    = r_d[0];
endmodule

// File: tb/tb_sub_word.sv
// Bench for sub_word: S-box reference derived from GF(2^8) inversion plus the
// affine map, directed FIPS vectors, a rotated full sweep with mid-run reset, and random traffic.

module tb_sub_word;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] S0_in = '0, S1_in = '0, S2_in = '0, S3_in = '0;
    logic       out_valid;
    logic [7:0] D0_out, D1_out, D2_out, D3_out;

    int checks = 0;
    int failures = 0;

    logic [7:0]  golden [256];
    logic [31:0] exp_d = '0;
    logic        exp_v = 1'b0;

    sub_word dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .S0_in(S0_in), .S1_in(S1_in), .S2_in(S2_in), .S3_in(S3_in),
        .out_valid(out_valid),
        .D0_out(D0_out), .D1_out(D1_out), .D2_out(D2_out), .D3_out(D3_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(a, 8'(y)) == 8'h01) return 8'(y);
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {golden[w[31:24]], golden[w[23:16]], golden[w[15:8]], golden[w[7:0]]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] dword();
        return {D0_out, D1_out, D2_out, D3_out};
    endfunction

    // Present one word (or idle), clock it in, update the model, then compare.
    task automatic step(input logic v, input logic [31:0] w, input string tag);
        in_valid = v;
        {S0_in, S1_in, S2_in, S3_in} = w;
        @(posedge clk);
        if (v) exp_d = subw(w);
        exp_v = v;
        #1;
        chk({tag, ".d"}, dword(), exp_d);
        chk({tag, ".v"}, {31'd0, out_valid}, {31'd0, exp_v});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) golden[i] = sbox_ref(8'(i));

        // Reset held over a few edges, then asserted again between edges.
        repeat (2) @(posedge clk);
        #1;
        chk("reset.d", dword(), 32'h0);
        chk("reset.v", {31'd0, out_valid}, 32'h0);
        rst = 1'b0;
        step(1'b1, 32'h01020304, "pre_async");
        #2 rst = 1'b1;
        #1;
        chk("async_rst.d", dword(), 32'h0);
        chk("async_rst.v", {31'd0, out_valid}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_d = '0; exp_v = 1'b0;
        step(1'b0, 32'hdeadbeef, "release_idle");

        // Directed vectors with expectations taken straight from FIPS-197.
        step(1'b1, 32'h20467567, "basic");
        chk("basic.const", dword(), 32'hb75a9d85);
        step(1'b1, 32'hcf4f3c09, "fips_kexp");
        chk("fips_kexp.const", dword(), 32'h8a84eb01);
        step(1'b1, 32'h000153ff, "bound_a");
        chk("bound_a.const", dword(), 32'h637ced16);
        step(1'b1, 32'h10807ffe, "bound_b");
        chk("bound_b.const", dword(), 32'hcacdd2bb);
        step(1'b0, 32'h55555555, "hold");
        chk("hold.const", dword(), 32'hcacdd2bb);
        step(1'b0, 32'haaaaaaaa, "hold2");

        // Full sweep, each lane on a different rotation; reset pulse at index 100.
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = {8'(i), 8'(i + 64), 8'(i + 128), 8'(i + 192)};
            if (i == 100) begin
                in_valid = 1'b1;
                {S0_in, S1_in, S2_in, S3_in} = w;
                #2 rst = 1'b1;
                #1;
                chk("sweep_rst.d", dword(), 32'h0);
                chk("sweep_rst.v", {31'd0, out_valid}, 32'h0);
                @(posedge clk);
                #1;
                chk("sweep_rst_edge.d", dword(), 32'h0);
                rst = 1'b0;
                exp_d = '0; exp_v = 1'b0;
            end
            step(1'b1, w, "sweep");
        end

        // Random traffic with random gaps.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 3) != 0), $urandom, "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
